// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle register-file CPU sequenced FETCH/EXEC/MEM/WB,
// with req/ack handshakes to external instruction and data memories.
module cpu_multicycle #(
  parameter int DATA_W = 8,
  parameter int PC_W = 8,
  parameter int REG_AW = 5,
  localparam int INSN_W = 4 + 2*REG_AW + DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_data,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc_out,
  output logic              zf_out,
  output logic              halted,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_state_nx;
  logic [PC_W-1:0] r_pc;
  logic r_zf;
  logic [INSN_W-1:0] r_ir;
  logic [DATA_W-1:0] r_res, r_addr, r_wdata;
  logic [DATA_W-1:0] r_rf [2**REG_AW];
  logic [3:0] w_op;
  logic [REG_AW-1:0] w_rd, w_rs, w_rt;
  logic [DATA_W-1:0] w_fld, w_a, w_b, w_alu;
  logic w_mem, w_wr, w_zupd, w_taken;
  assign {w_op, w_rd, w_rs, w_fld} = r_ir;
  assign w_rt = w_fld[REG_AW-1:0];
  assign w_a = r_rf[w_rs];
  assign w_b = r_rf[w_rt];
  assign w_mem = w_op == 4'd8 || w_op == 4'd9;
  assign w_wr = (w_op >= 4'd1 && w_op <= 4'd8) || w_op == 4'd13 || w_op == 4'd14;
  assign w_zupd = (w_op >= 4'd1 && w_op <= 4'd6) || w_op == 4'd13 || w_op == 4'd14;
  assign w_taken = w_op == 4'd10 || (w_op == 4'd11 && r_zf) || (w_op == 4'd12 && !r_zf);
  assign imem_addr = r_pc;
  assign pc_out = r_pc;
  assign zf_out = r_zf;
  assign dmem_addr = r_addr;
  assign dmem_wdata = r_wdata;
  assign dbg_rdata = r_rf[dbg_raddr];
  always_comb begin
    w_alu = '0;
    case (w_op)
      4'd1: w_alu = w_a + w_b;
      4'd2: w_alu = w_a - w_b;
      4'd3: w_alu = w_a & w_b;
      4'd4: w_alu = w_a | w_b;
      4'd5: w_alu = w_a ^ w_b;
      4'd6: w_alu = w_a + w_fld;
      4'd7: w_alu = w_fld;
      4'd13: w_alu = w_a << 1;
      4'd14: w_alu = w_a >> 1;
      default: w_alu = '0;
    endcase
  end
  always_ff @(posedge clk) r_state <= !rst ? S_FETCH : w_state_nx;
  // requests are gated by rst so a handshake is dropped as soon as reset is applied
  always_comb begin
    w_state_nx = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    halted = 1'b0;
    case (r_state)
      S_FETCH: begin
        imem_req = rst;
        if (imem_ack) w_state_nx = S_EXEC;
      end
      S_EXEC: w_state_nx = w_op == 4'd15 ? S_HALT : w_mem ? S_MEM : S_WB;
      S_MEM: begin
        dmem_req = rst;
        dmem_we = rst && w_op == 4'd9;
        if (dmem_ack) w_state_nx = S_WB;
      end
      S_WB: w_state_nx = S_FETCH;
      S_HALT: halted = 1'b1;
      default: w_state_nx = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc <= '0;
      r_zf <= 1'b0;
      r_ir <= '0;
      r_res <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      for (int i = 0; i < 2**REG_AW; i++) r_rf[i] <= '0;
    end else begin
      if (r_state == S_FETCH && imem_ack) r_ir <= imem_data;
      if (r_state == S_EXEC) begin
        r_res <= w_alu;
        r_addr <= w_a + w_fld;
        r_wdata <= r_rf[w_rd];
      end
      if (r_state == S_MEM && dmem_ack && w_op == 4'd8) r_res <= dmem_rdata;
      if (r_state == S_WB) begin
        if (w_wr && w_rd != '0) r_rf[w_rd] <= r_res;
        if (w_zupd) r_zf <= r_res == '0;
        r_pc <= w_taken ? w_fld[PC_W-1:0] : r_pc + PC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: directed and random programs against an instruction-level model,
// with latency-configurable instruction/data memory responders.
module tb_cpu_multicycle;
  localparam int IW = 22;
  logic clk = 0, rst = 0;
  logic imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, zf_out, halted;
  logic [7:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata, pc_out, dbg_rdata;
  logic [IW-1:0] imem_data;
  logic [4:0] dbg_raddr = '0;
  logic [IW-1:0] im [256];
  logic [7:0] dm [256];
  int il = 0, dl = 0, iw = 0, dwc = 0;
  int ftrace[$];
  int d_we_cyc, d_unstable, st_addr, st_wd;
  logic [7:0] pa, pwd;
  logic pwe;
  int m_rf [32];
  int m_dm [256];
  int m_pc, m_zf, m_cyc;
  int m_trace[$];
  int nvec = 0, nfail = 0;

  cpu_multicycle dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_out(pc_out), .zf_out(zf_out), .halted(halted),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  // instruction memory: acks after il wait cycles, logs every fetched address
  initial begin
    imem_ack = 0;
    imem_data = '0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (iw >= il) begin
          if (!imem_ack) ftrace.push_back(int'(imem_addr));
          imem_ack = 1;
          imem_data = im[imem_addr];
        end else imem_ack = 0;
        iw++;
      end else begin
        imem_ack = 0;
        iw = 0;
      end
    end
  end

  // data memory: acks after dl wait cycles, tracks request stability and store activity
  initial begin
    dmem_ack = 0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (dmem_req) begin
        if (dwc > 0 && (dmem_addr !== pa || dmem_we !== pwe || dmem_wdata !== pwd)) d_unstable++;
        pa = dmem_addr; pwe = dmem_we; pwd = dmem_wdata;
        if (dmem_we) begin
          d_we_cyc++;
          st_addr = int'(dmem_addr);
          st_wd = int'(dmem_wdata);
        end
        if (dwc >= dl) begin
          if (!dmem_ack && dmem_we) dm[dmem_addr] = dmem_wdata;
          dmem_ack = 1;
          dmem_rdata = dm[dmem_addr];
        end else dmem_ack = 0;
        dwc++;
      end else begin
        dmem_ack = 0;
        dwc = 0;
      end
    end
  end

  function automatic logic [IW-1:0] enc(input int op, input int rd, input int rs, input int f);
    return {4'(op), 5'(rd), 5'(rs), 8'(f)};
  endfunction

  task automatic fill_halt();
    for (int i = 0; i < 256; i++) im[i] = enc(15, 0, 0, 0);
  endtask

  // instruction-level reference: architectural effects plus cycle cost per instruction
  task automatic model_run(input int ilat, input int dlat);
    int op, rd, rs, f, a, b, res, npc;
    logic [IW-1:0] w;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    for (int i = 0; i < 256; i++) m_dm[i] = int'(dm[i]);
    m_pc = 0; m_zf = 0; m_cyc = 0;
    m_trace.delete();
    for (int s = 0; s < 1000; s++) begin
      w = im[m_pc];
      op = int'(w[21:18]); rd = int'(w[17:13]); rs = int'(w[12:8]); f = int'(w[7:0]);
      a = m_rf[rs]; b = m_rf[f % 32]; res = -1; npc = (m_pc + 1) % 256;
      m_trace.push_back(m_pc);
      if (op == 15) begin
        m_cyc += 2 + ilat;
        return;
      end
      m_cyc += 3 + ilat;
      case (op)
        1: res = (a + b) % 256;
        2: res = (a - b + 256) % 256;
        3: res = a & b;
        4: res = a | b;
        5: res = a ^ b;
        6: res = (a + f) % 256;
        7: res = f;
        8: begin res = m_dm[(a + f) % 256]; m_cyc += 1 + dlat; end
        9: begin m_dm[(a + f) % 256] = m_rf[rd]; m_cyc += 1 + dlat; end
        10: npc = f;
        11: if (m_zf == 1) npc = f;
        12: if (m_zf == 0) npc = f;
        13: res = (a * 2) % 256;
        14: res = a / 2;
        default: ;
      endcase
      if ((op >= 1 && op <= 6) || op == 13 || op == 14) m_zf = (res == 0) ? 1 : 0;
      if (res >= 0 && rd != 0) m_rf[rd] = res;
      m_pc = npc;
    end
  endtask

  task automatic run_prog(input int ilat, input int dlat, output int cyc);
    il = ilat; dl = dlat;
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    ftrace.delete();
    d_we_cyc = 0; d_unstable = 0; st_addr = -1; st_wd = -1;
    #1 rst = 1;
    cyc = 0;
    for (int k = 0; k < 4000 && !halted; k++) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    nvec++;
    if (halted !== 1'b1) begin
      nfail++;
      $display("FAIL run_timeout: halted=%b after %0d cycles, required 1", halted, cyc);
    end
  endtask

  task automatic test_reset();
    fill_halt();
    im[0] = enc(7, 1, 0, 5);
    im[1] = enc(7, 2, 0, 9);
    im[2] = enc(10, 0, 0, 2);
    il = 3; dl = 0;
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    repeat (40) @(posedge clk);
    for (int k = 0; k < 20 && !(imem_req && !imem_ack); k++) @(negedge clk);
    dbg_raddr = 1; #1;
    nvec++;
    if (dbg_rdata !== 8'd5) begin nfail++; $display("FAIL reset_pre_r1: got %0d, required 5", dbg_rdata); end
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (imem_req !== 1'b0) begin nfail++; $display("FAIL reset_req: got %b, required 0", imem_req); end
    nvec++;
    if (pc_out !== 8'd0) begin nfail++; $display("FAIL reset_pc: got %0d, required 0", pc_out); end
    nvec++;
    if (zf_out !== 1'b0 || halted !== 1'b0) begin
      nfail++; $display("FAIL reset_flags: zf=%b halted=%b, required 0 0", zf_out, halted);
    end
    for (int r = 1; r < 32; r++) begin
      dbg_raddr = 5'(r); #1;
      nvec++;
      if (dbg_rdata !== 8'd0) begin nfail++; $display("FAIL reset_r%0d: got %0d, required 0", r, dbg_rdata); end
    end
    rst = 1; #1;
    nvec++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
      nfail++; $display("FAIL reset_refetch: req=%b addr=%0d, required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu();
    int cyc;
    fill_halt();
    im[0] = enc(7, 1, 0, 200);
    im[1] = enc(7, 2, 0, 100);
    im[2] = enc(1, 3, 1, 2);
    run_prog(0, 0, cyc);
    dbg_raddr = 3; #1;
    nvec++;
    if (dbg_rdata !== 8'd44) begin nfail++; $display("FAIL alu_add_wrap: got %0d, required 44", dbg_rdata); end
    nvec++;
    if (zf_out !== 1'b0) begin nfail++; $display("FAIL alu_add_zf: got %b, required 0", zf_out); end
    nvec++;
    if (cyc != 11 || pc_out !== 8'd3) begin
      nfail++; $display("FAIL alu_add_timing: cycles=%0d pc=%0d, required 11 3", cyc, pc_out);
    end
    im[3] = enc(2, 4, 3, 3);
    run_prog(0, 0, cyc);
    dbg_raddr = 4; #1;
    nvec++;
    if (dbg_rdata !== 8'd0 || zf_out !== 1'b1) begin
      nfail++; $display("FAIL alu_sub_zero: r4=%0d zf=%b, required 0 1", dbg_rdata, zf_out);
    end
    nvec++;
    if (cyc != 14) begin nfail++; $display("FAIL alu_sub_timing: got %0d cycles, required 14", cyc); end
  endtask

  task automatic test_mem();
    int cyc;
    fill_halt();
    for (int i = 0; i < 256; i++) dm[i] = 8'(i + 1);
    dm[20] = 8'd0;
    im[0] = enc(7, 1, 0, 200);
    im[1] = enc(7, 2, 0, 100);
    im[2] = enc(1, 3, 1, 2);
    im[3] = enc(9, 3, 0, 20);
    im[4] = enc(8, 5, 0, 20);
    run_prog(0, 3, cyc);
    nvec++;
    if (d_we_cyc != 4 || d_unstable != 0) begin
      nfail++; $display("FAIL mem_st_hold: we_cycles=%0d unstable=%0d, required 4 0", d_we_cyc, d_unstable);
    end
    nvec++;
    if (st_addr != 20 || st_wd != 44) begin
      nfail++; $display("FAIL mem_st_bus: addr=%0d wdata=%0d, required 20 44", st_addr, st_wd);
    end
    dbg_raddr = 5; #1;
    nvec++;
    if (dbg_rdata !== 8'd44 || dm[20] !== 8'd44) begin
      nfail++; $display("FAIL mem_ld: r5=%0d mem20=%0d, required 44 44", dbg_rdata, dm[20]);
    end
    nvec++;
    if (cyc != 25) begin nfail++; $display("FAIL mem_timing: got %0d cycles, required 25", cyc); end
  endtask

  task automatic test_branch();
    int cyc;
    int exp_tr [12] = '{0, 1, 2, 4, 5, 16, 17, 255, 0, 1, 2, 3};
    for (int v = 0; v < 2; v++) begin
      int bad = 0;
      fill_halt();
      im[0] = enc(6, 7, 7, 1);
      im[1] = enc(6, 8, 7, 254);
      im[2] = enc(12, 0, 0, 4);
      im[4] = enc(2, 2, 1, 1);
      im[5] = enc(11, 0, 0, 16);
      im[16] = enc(12, 0, 0, 48);
      im[17] = enc(10, 0, 0, 255);
      im[255] = (v == 0) ? enc(0, 0, 0, 0) : enc(10, 0, 0, 0);
      run_prog(v, 0, cyc);
      for (int i = 0; i < 12 && i < ftrace.size(); i++) if (ftrace[i] != exp_tr[i]) bad++;
      nvec++;
      if (ftrace.size() != 12 || bad != 0) begin
        nfail++; $display("FAIL branch_trace%0d: len=%0d wrong=%0d, required 12 0", v, ftrace.size(), bad);
      end
      nvec++;
      if (cyc != 11 * (3 + v) + 2 + v || pc_out !== 8'd3 || zf_out !== 1'b1) begin
        nfail++; $display("FAIL branch_end%0d: cycles=%0d pc=%0d zf=%b, required %0d 3 1",
                          v, cyc, pc_out, zf_out, 11 * (3 + v) + 2 + v);
      end
    end
  endtask

  task automatic test_r0();
    int cyc;
    fill_halt();
    im[0] = enc(7, 1, 0, 9);
    im[1] = enc(7, 0, 0, 7);
    im[2] = enc(1, 1, 0, 0);
    run_prog(2, 0, cyc);
    dbg_raddr = 0; #1;
    nvec++;
    if (dbg_rdata !== 8'd0) begin nfail++; $display("FAIL r0_zero: got %0d, required 0", dbg_rdata); end
    dbg_raddr = 1; #1;
    nvec++;
    if (dbg_rdata !== 8'd0 || zf_out !== 1'b1) begin
      nfail++; $display("FAIL r0_add: r1=%0d zf=%b, required 0 1", dbg_rdata, zf_out);
    end
  endtask

  task automatic test_halt();
    int cyc, req_seen = 0;
    fill_halt();
    im[0] = enc(7, 1, 0, 3);
    run_prog(1, 0, cyc);
    nvec++;
    if (cyc != 7 || pc_out !== 8'd1) begin
      nfail++; $display("FAIL halt_entry: cycles=%0d pc=%0d, required 7 1", cyc, pc_out);
    end
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req || !halted) req_seen++;
    end
    nvec++;
    if (req_seen != 0) begin nfail++; $display("FAIL halt_hold: %0d active cycles, required 0", req_seen); end
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    nvec++;
    if (halted !== 1'b0) begin nfail++; $display("FAIL halt_reset: halted=%b, required 0", halted); end
    rst = 1; #1;
    nvec++;
    if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
      nfail++; $display("FAIL halt_refetch: req=%b addr=%0d, required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      int n, cyc, ilat, dlat, bad_dm, bad_tr, op, f;
      n = $urandom_range(8, 40);
      ilat = $urandom_range(0, 3);
      dlat = $urandom_range(0, 3);
      fill_halt();
      for (int i = 0; i < 256; i++) dm[i] = 8'($urandom);
      // jumps only go forward and all paths end on the HALT at address n
      for (int i = 0; i < n; i++) begin
        op = $urandom_range(0, 14);
        f = $urandom_range(0, 255);
        if (op >= 1 && op <= 5) f = $urandom_range(0, 7);
        if (op >= 10 && op <= 12) f = $urandom_range(i + 1, n);
        im[i] = enc(op, $urandom_range(0, 7), $urandom_range(0, 7), f);
      end
      model_run(ilat, dlat);
      run_prog(ilat, dlat, cyc);
      for (int r = 0; r < 32; r++) begin
        dbg_raddr = 5'(r); #1;
        nvec++;
        if (dbg_rdata !== 8'(m_rf[r])) begin
          nfail++; $display("FAIL rand%0d_r%0d: got %0d, required %0d", t, r, dbg_rdata, m_rf[r]);
        end
      end
      nvec++;
      if (pc_out !== 8'(m_pc) || zf_out !== 1'(m_zf)) begin
        nfail++; $display("FAIL rand%0d_arch: pc=%0d zf=%b, required %0d %0d", t, pc_out, zf_out, m_pc, m_zf);
      end
      nvec++;
      if (cyc != m_cyc) begin nfail++; $display("FAIL rand%0d_cycles: got %0d, required %0d", t, cyc, m_cyc); end
      bad_tr = 0;
      for (int i = 0; i < ftrace.size() && i < m_trace.size(); i++) if (ftrace[i] != m_trace[i]) bad_tr++;
      nvec++;
      if (ftrace.size() != m_trace.size() || bad_tr != 0) begin
        nfail++; $display("FAIL rand%0d_trace: len=%0d wrong=%0d, required %0d 0", t, ftrace.size(), bad_tr, m_trace.size());
      end
      bad_dm = 0;
      for (int i = 0; i < 256; i++) if (dm[i] !== 8'(m_dm[i])) bad_dm++;
      nvec++;
      if (bad_dm != 0) begin nfail++; $display("FAIL rand%0d_dmem: %0d bytes differ, required 0", t, bad_dm); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) dm[i] = '0;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_r0();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
